soc_mem_arbiter: RTL and testbench
==================================

Name: soc_mem_arbiter

Overview:
Shares the SOC's single RAM port between two requesters: the CPU instruction-fetch port (I) and the CPU load/store port (D). Fixed-latency RAM, one transaction in flight at a time, round-robin on conflict. Sits between the CPU and the RAM in the SOC top level, and sequences every memory access the CPU makes.

Parameters:
ADDR_WIDTH, 32, byte-address width on all ports
LATENCY, 1, RAM read latency in cycles from the strobe cycle to valid mem_rdata; legal range 1..7

Ports:
CLK  in  1  system clock, rising edge
RESETN  in  1  asynchronous active-low reset
i_req  in  1  fetch request; held with i_addr until i_ack
i_addr  in  ADDR_WIDTH  fetch address, word aligned
i_rdata  out  32  fetched word; valid when i_ack=1
i_ack  out  1  one-cycle completion pulse for I
d_req  in  1  load/store request; held with d_addr, d_wmask and d_wdata until d_ack
d_addr  in  ADDR_WIDTH  data address
d_wmask  in  4  byte write mask; 4'b0000 means read
d_wdata  in  32  store data
d_rdata  out  32  load data; valid when d_ack=1 on a read
d_ack  out  1  one-cycle completion pulse for D
mem_addr  out  ADDR_WIDTH  RAM address, registered
mem_rstrb  out  1  RAM read strobe, registered, one cycle wide
mem_wmask  out  4  RAM byte write enables, registered, one cycle wide
mem_wdata  out  32  RAM write data, registered
mem_rdata  in  32  RAM read data

Behaviour:
- Reset (async, RESETN=0): state IDLE; all outputs 0; latency counter 0; last_grant=D, so I wins the first conflict.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: samples i_req and d_req.
  - Neither asserted: stay in IDLE.
  - Only one asserted: grant it.
  - Both asserted: grant the requester not equal to last_grant.
  - On grant: register winner id, set last_grant to the winner, go to ISSUE.
- ISSUE (1 cycle): mem_addr = winner address.
  - Read (I always; D with d_wmask=0): mem_rstrb=1, mem_wmask=0.
  - Write: mem_wmask=d_wmask, mem_wdata=d_wdata, mem_rstrb=0.
  - Strobes are 0 in every other state. mem_addr and mem_wdata hold their last value outside ISSUE.
  - Read with LATENCY=1: go to DONE. Read with LATENCY>1: load counter with LATENCY-1 and go to WAIT. Write: go to DONE.
- WAIT: decrement counter each cycle; go to DONE when it reaches 1.
- DONE (1 cycle):
  - Pulse the winner's ack.
  - On a read, the winner's rdata = mem_rdata, captured in DONE and held until that requester's next read completes.
  - Go to IDLE.
- Timing (req first seen in IDLE at cycle 0): strobe at cycle 1. Read ack at cycle 1+LATENCY. Write ack at cycle 2.
- Throughput: reads take 2+LATENCY cycles, writes 3, including the IDLE cycle.
- i_ack and d_ack are never asserted together, and ack never comes without a prior grant.
- The loser of a conflict keeps its req high and is granted at the next IDLE: no starvation. Alternation is strict while both requesters stay asserted.
- A req still high in the cycle after its ack is treated as a new request.
- Inputs from the granted requester are latched in IDLE; later changes before ack are ignored.
- Req dropped before its ack is unsupported (protocol violation); the transaction completes anyway.
- Reset mid-transaction: immediate abort. Strobes and acks go to 0 and no ack is produced; last_grant returns to D.
- Address is passed through unmodified; no alignment checks.

Test Plan:
1. Reset, then i_req=1, i_addr=0x10, LATENCY=1, RAM returns 0xDEADBEEF -> mem_rstrb=1 with mem_addr=0x10 at cycle 1; i_ack=1 with i_rdata=0xDEADBEEF at cycle 2; d_ack stays 0.
2. d_req=1, d_addr=0x20, d_wmask=4'b0011, d_wdata=0x12345678 -> at cycle 1 mem_wmask=4'b0011, mem_wdata=0x12345678, mem_rstrb=0; d_ack at cycle 2; d_rdata unchanged.
3. i_req and d_req both held high from reset for 4 grants -> grant order I, D, I, D; acks at cycles 2, 5, 8, 11; acks never overlap.
4. LATENCY=3, d read of 0x40 with RAM data 0xA5A5A5A5 -> mem_rstrb at cycle 1 only; d_ack with d_rdata=0xA5A5A5A5 at cycle 4.
5. RESETN pulled low in the WAIT state of a LATENCY=3 read -> all outputs 0 immediately; no ack afterwards. After release, with both reqs high, I is granted first.
6. i_req held through two back-to-back fetches at 0x0 then 0x4, with no d_req -> i_ack at cycles 2 and 5; mem_addr 0x0 then 0x4.

Source files
------------

// File: rtl/soc_mem_arbiter_if.sv
// CPU fetch (I), CPU load/store (D) and single RAM port bundled for the memory arbiter.
// The slave modport is the arbiter's view; master is the CPU/RAM side.
interface soc_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32
) ();
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [31:0]           i_rdata;
    logic                  i_ack;

    logic                  d_req;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [3:0]            d_wmask;
    logic [31:0]           d_wdata;
    logic [31:0]           d_rdata;
    logic                  d_ack;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rstrb;
    logic [3:0]            mem_wmask;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_wmask, d_wdata, mem_rdata,
        output i_rdata, i_ack, d_rdata, d_ack, mem_addr, mem_rstrb, mem_wmask, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_addr, d_wmask, d_wdata, mem_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack, mem_addr, mem_rstrb, mem_wmask, mem_wdata
    );
endinterface

// File: rtl/soc_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency RAM port between CPU fetch (I) and
// load/store (D); one transaction in flight, sequenced IDLE -> ISSUE -> [WAIT] -> DONE.
module soc_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LATENCY    = 1
) (
    input  logic             CLK,
    input  logic             RESETN,
    soc_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e                state_q, state_d;
    logic                  win_d_q, win_d_d;    // current winner is the D port
    logic                  last_d_q, last_d_d;  // last grant went to D
    logic                  we_q, we_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  mem_rstrb_q, mem_rstrb_d;
    logic [3:0]            mem_wmask_q, mem_wmask_d;
    logic [31:0]           i_rdata_q, i_rdata_d;
    logic [31:0]           d_rdata_q, d_rdata_d;
    logic                  pick_dport;
    logic                  done_rd;

    // D wins when alone, or on a conflict when I was served last.
    assign pick_dport = bus.d_req & (~bus.i_req | ~last_d_q);

    always_comb begin
        state_d     = state_q;
        win_d_d     = win_d_q;
        last_d_d    = last_d_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rstrb_d = 1'b0;
        mem_wmask_d = 4'b0000;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (bus.i_req || bus.d_req) begin
                    win_d_d  = pick_dport;
                    last_d_d = pick_dport;
                    state_d  = StIssue;
                    if (pick_dport) begin
                        mem_addr_d  = bus.d_addr;
                        we_d        = |bus.d_wmask;
                        mem_wmask_d = bus.d_wmask;
                        mem_rstrb_d = ~|bus.d_wmask;
                        if (|bus.d_wmask) begin
                            mem_wdata_d = bus.d_wdata;
                        end
                    end else begin
                        mem_addr_d  = bus.i_addr;
                        we_d        = 1'b0;
                        mem_rstrb_d = 1'b1;
                    end
                end
            end
            StIssue: begin
                if (we_q || LATENCY <= 1) begin
                    state_d = StDone;
                end else begin
                    cnt_d   = 3'(LATENCY - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!we_q) begin
                    if (win_d_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end else begin
                        i_rdata_d = bus.mem_rdata;
                    end
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= StIdle;
            win_d_q     <= 1'b0;
            last_d_q    <= 1'b1;
            we_q        <= 1'b0;
            cnt_q       <= 3'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            mem_rstrb_q <= 1'b0;
            mem_wmask_q <= 4'b0000;
            i_rdata_q   <= 32'h0;
            d_rdata_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            win_d_q     <= win_d_d;
            last_d_q    <= last_d_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rstrb_q <= mem_rstrb_d;
            mem_wmask_q <= mem_wmask_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // RAM data is only valid during DONE, so it is forwarded there and held afterwards.
    assign done_rd       = (state_q == StDone) && !we_q;
    assign bus.i_ack     = (state_q == StDone) && !win_d_q;
    assign bus.d_ack     = (state_q == StDone) && win_d_q;
    assign bus.i_rdata   = (done_rd && !win_d_q) ? bus.mem_rdata : i_rdata_q;
    assign bus.d_rdata   = (done_rd && win_d_q) ? bus.mem_rdata : d_rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_rstrb = mem_rstrb_q;
    assign bus.mem_wmask = mem_wmask_q;
endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Self-checking bench for soc_mem_arbiter: one LATENCY=1 and one LATENCY=3 instance,
// each fed by a fixed-latency RAM model; acks are matched against a scoreboard queue.
module tb_soc_mem_arbiter;
    localparam logic [31:0] BAD = 32'hBAD0_BAD0;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn1;
    logic        rstn3;
    logic [31:0] p1, p2;
    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        sbq[$];

    always #5 clk = ~clk;

    soc_mem_arbiter_if #(.ADDR_WIDTH(32)) bus1 ();
    soc_mem_arbiter_if #(.ADDR_WIDTH(32)) bus3 ();

    soc_mem_arbiter #(.ADDR_WIDTH(32), .LATENCY(1)) dut1 (.CLK(clk), .RESETN(rstn1), .bus(bus1));
    soc_mem_arbiter #(.ADDR_WIDTH(32), .LATENCY(3)) dut3 (.CLK(clk), .RESETN(rstn3), .bus(bus3));

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        case (a)
            32'h00:  return 32'h1111_1111;
            32'h04:  return 32'h2222_2222;
            32'h10:  return 32'hDEAD_BEEF;
            32'h20:  return 32'hCAFE_F00D;
            32'h40:  return 32'hA5A5_A5A5;
            32'h44:  return 32'h5A5A_5A5A;
            32'h48:  return 32'hC3C3_C3C3;
            default: return a ^ 32'h5555_0000;
        endcase
    endfunction

    // RAM models: data valid LATENCY cycles after the strobe cycle, garbage otherwise.
    always @(posedge clk) begin
        bus1.mem_rdata <= bus1.mem_rstrb ? ram_word(bus1.mem_addr) : BAD;
        p1             <= bus3.mem_rstrb ? ram_word(bus3.mem_addr) : BAD;
        p2             <= p1;
        bus3.mem_rdata <= p2;
    end

    task automatic idle_inputs();
        bus1.i_req = 1'b0; bus1.i_addr = 32'h0; bus1.d_req = 1'b0; bus1.d_addr = 32'h0;
        bus1.d_wmask = 4'h0; bus1.d_wdata = 32'h0;
        bus3.i_req = 1'b0; bus3.i_addr = 32'h0; bus3.d_req = 1'b0; bus3.d_addr = 32'h0;
        bus3.d_wmask = 4'h0; bus3.d_wdata = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn1 = 1'b0;
        rstn3 = 1'b0;
        #1;
        n_cmp++;
        if ({bus1.i_ack, bus1.d_ack, bus1.i_rdata, bus1.d_rdata, bus1.mem_addr, bus1.mem_rstrb,
             bus1.mem_wmask, bus1.mem_wdata} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs_l1: got ack=%b%b rstrb=%b wmask=%h addr=%h, want all 0",
                     bus1.i_ack, bus1.d_ack, bus1.mem_rstrb, bus1.mem_wmask, bus1.mem_addr);
        end
        n_cmp++;
        if ({bus3.i_ack, bus3.d_ack, bus3.i_rdata, bus3.d_rdata, bus3.mem_addr, bus3.mem_rstrb,
             bus3.mem_wmask, bus3.mem_wdata} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs_l3: got ack=%b%b rstrb=%b wmask=%h addr=%h, want all 0",
                     bus3.i_ack, bus3.d_ack, bus3.mem_rstrb, bus3.mem_wmask, bus3.mem_addr);
        end
        repeat (2) @(posedge clk);
        #1;
        rstn1 = 1'b1;
        rstn3 = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_fetch();
        @(posedge clk);
        #1;
        bus1.i_req  = 1'b1;
        bus1.i_addr = 32'h10;
        sbq.push_back('{is_d: 1'b0, data: 32'hDEAD_BEEF, cyc: 2});
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_cmp++;
                if ({bus1.mem_rstrb, bus1.mem_wmask, bus1.mem_addr} !== {1'b1, 4'h0, 32'h10}) begin
                    n_err++;
                    $display("FAIL fetch_issue: got rstrb=%b wmask=%h addr=%h, want 1/0/00000010",
                             bus1.mem_rstrb, bus1.mem_wmask, bus1.mem_addr);
                end
            end
            if (bus1.i_ack || bus1.d_ack) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL fetch_ack: got ack i=%b d=%b at cycle %0d, want none",
                             bus1.i_ack, bus1.d_ack, c);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if ({bus1.d_ack, bus1.i_ack, c, bus1.i_rdata} !== {e.is_d, !e.is_d, e.cyc, e.data}) begin
                        n_err++;
                        $display("FAIL fetch_ack: got d=%b i=%b cyc=%0d data=%h, want d=%b cyc=%0d data=%h",
                                 bus1.d_ack, bus1.i_ack, c, bus1.i_rdata, e.is_d, e.cyc, e.data);
                    end
                    bus1.i_req = 1'b0;
                end
            end
        end
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL fetch_timeout: got %0d pending, want 0", sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_write();
        @(posedge clk);
        #1;
        bus1.d_req   = 1'b1;
        bus1.d_addr  = 32'h20;
        bus1.d_wmask = 4'b0011;
        bus1.d_wdata = 32'h1234_5678;
        sbq.push_back('{is_d: 1'b1, data: 32'h0, cyc: 2});
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_cmp++;
                if ({bus1.mem_rstrb, bus1.mem_wmask, bus1.mem_wdata, bus1.mem_addr} !==
                    {1'b0, 4'b0011, 32'h1234_5678, 32'h20}) begin
                    n_err++;
                    $display("FAIL write_issue: got rstrb=%b wmask=%b wdata=%h addr=%h, want 0/0011/12345678/00000020",
                             bus1.mem_rstrb, bus1.mem_wmask, bus1.mem_wdata, bus1.mem_addr);
                end
            end
            if (c == 2) begin
                n_cmp++;
                if (bus1.mem_wmask !== 4'b0000) begin
                    n_err++;
                    $display("FAIL write_strobe_width: got wmask=%b, want 0000", bus1.mem_wmask);
                end
            end
            if (bus1.i_ack || bus1.d_ack) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL write_ack: got ack i=%b d=%b at cycle %0d, want none",
                             bus1.i_ack, bus1.d_ack, c);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if ({bus1.d_ack, bus1.i_ack, c, bus1.d_rdata} !== {e.is_d, !e.is_d, e.cyc, e.data}) begin
                        n_err++;
                        $display("FAIL write_ack: got d=%b i=%b cyc=%0d d_rdata=%h, want d=%b cyc=%0d d_rdata=%h",
                                 bus1.d_ack, bus1.i_ack, c, bus1.d_rdata, e.is_d, e.cyc, e.data);
                    end
                    bus1.d_req   = 1'b0;
                    bus1.d_wmask = 4'h0;
                end
            end
        end
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL write_timeout: got %0d pending, want 0", sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_arbitration();
        @(posedge clk);
        #1;
        rstn1        = 1'b0;
        bus1.i_req   = 1'b1;
        bus1.i_addr  = 32'h10;
        bus1.d_req   = 1'b1;
        bus1.d_addr  = 32'h20;
        bus1.d_wmask = 4'h0;
        @(posedge clk);
        #1;
        rstn1 = 1'b1;
        sbq.push_back('{is_d: 1'b0, data: 32'hDEAD_BEEF, cyc: 2});
        sbq.push_back('{is_d: 1'b1, data: 32'hCAFE_F00D, cyc: 5});
        sbq.push_back('{is_d: 1'b0, data: 32'hDEAD_BEEF, cyc: 8});
        sbq.push_back('{is_d: 1'b1, data: 32'hCAFE_F00D, cyc: 11});
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus1.i_ack && bus1.d_ack) begin
                n_err++;
                $display("FAIL arb_overlap: got both acks at cycle %0d, want at most one", c);
            end
            if (bus1.i_ack || bus1.d_ack) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL arb_ack: got ack i=%b d=%b at cycle %0d, want none",
                             bus1.i_ack, bus1.d_ack, c);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if ({bus1.d_ack, c, (bus1.d_ack ? bus1.d_rdata : bus1.i_rdata)} !==
                        {e.is_d, e.cyc, e.data}) begin
                        n_err++;
                        $display("FAIL arb_order: got d=%b cyc=%0d data=%h, want d=%b cyc=%0d data=%h",
                                 bus1.d_ack, c, (bus1.d_ack ? bus1.d_rdata : bus1.i_rdata),
                                 e.is_d, e.cyc, e.data);
                    end
                    if (sbq.size() == 0) begin
                        bus1.i_req = 1'b0;
                        bus1.d_req = 1'b0;
                    end
                end
            end
        end
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL arb_timeout: got %0d pending, want 0", sbq.size());
        end
        sbq.delete();
        bus1.i_req = 1'b0;
        bus1.d_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(posedge clk);
        #1;
        bus1.i_req  = 1'b1;
        bus1.i_addr = 32'h0;
        sbq.push_back('{is_d: 1'b0, data: 32'h1111_1111, cyc: 2});
        sbq.push_back('{is_d: 1'b0, data: 32'h2222_2222, cyc: 5});
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 1 || c == 4) begin
                n_cmp++;
                if ({bus1.mem_rstrb, bus1.mem_addr} !== {1'b1, (c == 1) ? 32'h0 : 32'h4}) begin
                    n_err++;
                    $display("FAIL b2b_issue: got rstrb=%b addr=%h at cycle %0d, want 1/%h",
                             bus1.mem_rstrb, bus1.mem_addr, c, (c == 1) ? 32'h0 : 32'h4);
                end
            end
            if (bus1.i_ack || bus1.d_ack) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_ack: got ack i=%b d=%b at cycle %0d, want none",
                             bus1.i_ack, bus1.d_ack, c);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if ({bus1.d_ack, bus1.i_ack, c, bus1.i_rdata} !== {e.is_d, !e.is_d, e.cyc, e.data}) begin
                        n_err++;
                        $display("FAIL b2b_ack: got d=%b i=%b cyc=%0d data=%h, want d=%b cyc=%0d data=%h",
                                 bus1.d_ack, bus1.i_ack, c, bus1.i_rdata, e.is_d, e.cyc, e.data);
                    end
                    if (sbq.size() == 1) bus1.i_addr = 32'h4;
                    else bus1.i_req = 1'b0;
                end
            end
        end
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL b2b_timeout: got %0d pending, want 0", sbq.size());
        end
        sbq.delete();
        bus1.i_req = 1'b0;
    endtask

    task automatic test_wait_latency();
        @(posedge clk);
        #1;
        bus3.d_req   = 1'b1;
        bus3.d_addr  = 32'h40;
        bus3.d_wmask = 4'h0;
        sbq.push_back('{is_d: 1'b1, data: 32'hA5A5_A5A5, cyc: 4});
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus3.mem_rstrb !== (c == 1)) begin
                n_err++;
                $display("FAIL lat3_rstrb: got %b at cycle %0d, want %b", bus3.mem_rstrb, c, (c == 1));
            end
            if (c == 2) begin
                // Changes after the grant must not reach the RAM or the result.
                bus3.d_addr  = 32'h44;
                bus3.d_wmask = 4'hF;
            end
            if (bus3.i_ack || bus3.d_ack) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL lat3_ack: got ack i=%b d=%b at cycle %0d, want none",
                             bus3.i_ack, bus3.d_ack, c);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if ({bus3.d_ack, bus3.i_ack, c, bus3.d_rdata} !== {e.is_d, !e.is_d, e.cyc, e.data}) begin
                        n_err++;
                        $display("FAIL lat3_ack: got d=%b i=%b cyc=%0d data=%h, want d=%b cyc=%0d data=%h",
                                 bus3.d_ack, bus3.i_ack, c, bus3.d_rdata, e.is_d, e.cyc, e.data);
                    end
                    bus3.d_req   = 1'b0;
                    bus3.d_wmask = 4'h0;
                end
            end
        end
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL lat3_timeout: got %0d pending, want 0", sbq.size());
        end
        sbq.delete();
        bus3.d_req   = 1'b0;
        bus3.d_wmask = 4'h0;
    endtask

    task automatic test_reset_abort();
        @(posedge clk);
        #1;
        bus3.d_req  = 1'b1;
        bus3.d_addr = 32'h48;
        for (int c = 0; c < 3; c++) @(negedge clk);
        rstn3 = 1'b0;
        #1;
        n_cmp++;
        if ({bus3.i_ack, bus3.d_ack, bus3.i_rdata, bus3.d_rdata, bus3.mem_addr, bus3.mem_rstrb,
             bus3.mem_wmask, bus3.mem_wdata} !== '0) begin
            n_err++;
            $display("FAIL abort_outputs: got ack=%b%b d_rdata=%h addr=%h rstrb=%b, want all 0",
                     bus3.i_ack, bus3.d_ack, bus3.d_rdata, bus3.mem_addr, bus3.mem_rstrb);
        end
        bus3.i_req  = 1'b1;
        bus3.i_addr = 32'h40;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus3.i_ack, bus3.d_ack} !== 2'b00) begin
                n_err++;
                $display("FAIL abort_no_ack: got i=%b d=%b in reset, want 00", bus3.i_ack, bus3.d_ack);
            end
        end
        @(posedge clk);
        #1;
        rstn3 = 1'b1;
        sbq.push_back('{is_d: 1'b0, data: 32'hA5A5_A5A5, cyc: 4});
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_cmp++;
                if ({bus3.mem_rstrb, bus3.mem_addr} !== {1'b1, 32'h40}) begin
                    n_err++;
                    $display("FAIL abort_first_grant: got rstrb=%b addr=%h, want 1/00000040",
                             bus3.mem_rstrb, bus3.mem_addr);
                end
            end
            if (bus3.i_ack || bus3.d_ack) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL abort_ack: got ack i=%b d=%b at cycle %0d, want none",
                             bus3.i_ack, bus3.d_ack, c);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if ({bus3.d_ack, bus3.i_ack, c, bus3.i_rdata} !== {e.is_d, !e.is_d, e.cyc, e.data}) begin
                        n_err++;
                        $display("FAIL abort_ack: got d=%b i=%b cyc=%0d data=%h, want d=%b cyc=%0d data=%h",
                                 bus3.d_ack, bus3.i_ack, c, bus3.i_rdata, e.is_d, e.cyc, e.data);
                    end
                    bus3.i_req = 1'b0;
                    bus3.d_req = 1'b0;
                end
            end
        end
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL abort_timeout: got %0d pending, want 0", sbq.size());
        end
        sbq.delete();
        bus3.i_req = 1'b0;
        bus3.d_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write();
        test_arbitration();
        test_back_to_back();
        test_wait_latency();
        test_reset_abort();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
